// File: rtl/uart_tx_if.sv
// Byte-write port and line/status signals of the UART transmitter.
interface uart_tx_if;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic       ovf;

    // Byte producer side
    modport master (
        output pi_data,
        output pi_flag,
        input  tx,
        input  busy,
        input  tx_done,
        input  ovf
    );

    // Transmitter side
    modport slave (
        input  pi_data,
        input  pi_flag,
        output tx,
        output busy,
        output tx_done,
        output ovf
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits; one-entry hold register lets the next byte queue behind
// the frame on the wire so frames go out back-to-back.
module uart_tx #(
    parameter int unsigned UART_BPS   = 9600,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic     sys_clk,
    input  logic     sys_rst_n,
    uart_tx_if.slave bus
);

    localparam int unsigned BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned BIT_W        = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [7:0]         shifter;
    logic               parity_bit;
    logic [7:0]         hold_data;
    logic               hold_valid;
    logic               tx_reg;
    logic               busy_reg;
    logic               tx_done_reg;
    logic               ovf_reg;

    logic baud_end;
    logic baud_pre_end;
    logic last_stop_bit;
    logic stop_last;
    logic drain;
    logic hold_wr;
    logic hold_valid_nxt;
    logic fsm_idle_nxt;

    // Bit-timing and hold-register handoff decodes
    assign baud_end       = (baud_cnt == CNT_W'(BAUD_CNT_MAX - 1));
    assign baud_pre_end   = (baud_cnt == CNT_W'(BAUD_CNT_MAX - 2));
    assign last_stop_bit  = (state == STOP) && (bit_cnt == BIT_W'(STOP_BITS - 1));
    assign stop_last      = last_stop_bit && baud_end;
    assign drain          = hold_valid && ((state == IDLE) || stop_last);
    assign hold_wr        = bus.pi_flag && (!hold_valid || drain);
    assign hold_valid_nxt = hold_wr || (hold_valid && !drain);
    assign fsm_idle_nxt   = ((state == IDLE) || stop_last) && !hold_valid;

    // Frame sequencer, hold register and registered line/status outputs
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            shifter     <= '0;
            parity_bit  <= 1'b0;
            hold_data   <= '0;
            hold_valid  <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            tx_done_reg <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            tx_done_reg <= last_stop_bit && baud_pre_end;
            ovf_reg     <= bus.pi_flag && hold_valid && !drain;
            busy_reg    <= !fsm_idle_nxt || hold_valid_nxt;
            hold_valid  <= hold_valid_nxt;
            if (hold_wr) begin
                hold_data <= bus.pi_data;
            end

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx_reg   <= 1'b1;
                    if (hold_valid) begin
                        shifter    <= hold_data;
                        parity_bit <= (^hold_data) ^ 1'(PARITY_ODD);
                        state      <= START;
                        tx_reg     <= 1'b0;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        tx_reg   <= shifter[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_W'(7)) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_reg <= parity_bit;
                            end else begin
                                state  <= STOP;
                                tx_reg <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shifter <= {1'b0, shifter[7:1]};
                            tx_reg  <= shifter[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= STOP;
                        tx_reg   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (last_stop_bit) begin
                            bit_cnt <= '0;
                            if (hold_valid) begin
                                shifter    <= hold_data;
                                parity_bit <= (^hold_data) ^ 1'(PARITY_ODD);
                                state      <= START;
                                tx_reg     <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                tx_reg <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx      = tx_reg;
    assign bus.busy    = busy_reg;
    assign bus.tx_done = tx_done_reg;
    assign bus.ovf     = ovf_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: 8N1 instance plus even/odd parity 2-stop instances,
// all fed from one byte strobe; frames are checked by mid-bit sampling of tx.
module tb_uart_tx;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] pi_data;
    logic       pi_flag;

    int n_vec;
    int n_err;

    uart_tx_if if_n1 ();
    uart_tx_if if_e2 ();
    uart_tx_if if_o2 ();

    assign if_n1.pi_data = pi_data;
    assign if_n1.pi_flag = pi_flag;
    assign if_e2.pi_data = pi_data;
    assign if_e2.pi_flag = pi_flag;
    assign if_o2.pi_data = pi_data;
    assign if_o2.pi_flag = pi_flag;

    uart_tx #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_n1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_n1.slave));
    uart_tx #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
        u_e2 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_e2.slave));
    uart_tx #(.UART_BPS(5_000_000), .CLK_FREQ(50_000_000), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
        u_o2 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(if_o2.slave));

    logic [2:0] tx_w, busy_w, done_w, ovf_w;
    assign tx_w   = {if_o2.tx,      if_e2.tx,      if_n1.tx};
    assign busy_w = {if_o2.busy,    if_e2.busy,    if_n1.busy};
    assign done_w = {if_o2.tx_done, if_e2.tx_done, if_n1.tx_done};
    assign ovf_w  = {if_o2.ovf,     if_e2.ovf,     if_n1.ovf};

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // One-cycle write strobe; returns just after the edge that samples it
    task automatic strobe(input logic [7:0] b);
        @(posedge sys_clk);
        #1;
        pi_data = b;
        pi_flag = 1'b1;
        @(posedge sys_clk);
        #1;
        pi_flag = 1'b0;
    endtask

    // Sample one instance on falling edges: index 0 is the cycle after the strobe edge;
    // slot j is sampled mid-bit at index 5+10j
    task automatic capture(input int sel, input int nslots, output logic [31:0] bits,
                           output int first_low, output int done_cnt, output int done_idx,
                           output int ovf_cnt, output int busy_low);
        bits      = '0;
        first_low = -1;
        done_cnt  = 0;
        done_idx  = -1;
        ovf_cnt   = 0;
        busy_low  = 0;
        for (int i = 0; i <= nslots * 10; i++) begin
            @(negedge sys_clk);
            if ((i % 10) == 5) bits[i / 10] = tx_w[sel];
            if (first_low < 0 && tx_w[sel] == 1'b0) first_low = i;
            if (done_w[sel]) begin
                done_cnt++;
                if (done_idx < 0) done_idx = i;
            end
            if (ovf_w[sel]) ovf_cnt++;
            if (!busy_w[sel]) busy_low++;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_w != 3'b000 && k < 2000) begin
            @(negedge sys_clk);
            k++;
        end
        n_vec++;
        if (busy_w !== 3'b000) begin
            n_err++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, expected 000", busy_w, k);
        end
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        pi_flag   = 1'b0;
        pi_data   = 8'h00;
        repeat (3) @(negedge sys_clk);
        n_vec++;
        if (tx_w !== 3'b111) begin n_err++; $display("FAIL reset_tx: got %b expected 111", tx_w); end
        n_vec++;
        if (busy_w !== 3'b000) begin n_err++; $display("FAIL reset_busy: got %b expected 000", busy_w); end
        n_vec++;
        if (done_w !== 3'b000) begin n_err++; $display("FAIL reset_done: got %b expected 000", done_w); end
        n_vec++;
        if (ovf_w !== 3'b000) begin n_err++; $display("FAIL reset_ovf: got %b expected 000", ovf_w); end
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic test_single_byte();
        logic [31:0] bits;
        int fl, dc, di, oc, bl;
        strobe(8'h55);
        pi_data = 8'hFF;
        capture(0, 10, bits, fl, dc, di, oc, bl);
        n_vec++;
        if (bits[9:0] !== {1'b1, 8'h55, 1'b0}) begin n_err++; $display("FAIL single_frame: got %h expected %h", bits[9:0], {1'b1, 8'h55, 1'b0}); end
        n_vec++;
        if (fl !== 1) begin n_err++; $display("FAIL single_latency: first low at %0d expected 1", fl); end
        n_vec++;
        if (dc !== 1 || di !== 100) begin n_err++; $display("FAIL single_done: count %0d at %0d expected 1 at 100", dc, di); end
        n_vec++;
        if (bl !== 0) begin n_err++; $display("FAIL single_busy: busy low %0d cycles expected 0", bl); end
        @(negedge sys_clk);
        n_vec++;
        if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin n_err++; $display("FAIL single_after: busy=%b tx=%b expected 0 1", busy_w[0], tx_w[0]); end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] bits;
        int fl, dc, di, oc, bl;
        strobe(8'hA3);
        fork
            capture(0, 20, bits, fl, dc, di, oc, bl);
            begin
                repeat (18) @(posedge sys_clk);
                strobe(8'h3C);
            end
        join
        n_vec++;
        if (bits[19:0] !== {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA3, 1'b0}) begin n_err++; $display("FAIL b2b_frames: got %h expected %h", bits[19:0], {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA3, 1'b0}); end
        n_vec++;
        if (dc !== 2) begin n_err++; $display("FAIL b2b_done: got %0d expected 2", dc); end
        n_vec++;
        if (bl !== 0) begin n_err++; $display("FAIL b2b_gap: busy low %0d cycles expected 0", bl); end
        n_vec++;
        if (oc !== 0) begin n_err++; $display("FAIL b2b_ovf: got %0d expected 0", oc); end
        wait_idle();
    endtask

    task automatic test_overflow();
        logic [31:0] bits;
        int fl, dc, di, oc, bl;
        strobe(8'h11);
        fork
            capture(0, 20, bits, fl, dc, di, oc, bl);
            begin
                repeat (18) @(posedge sys_clk);
                strobe(8'h22);
                repeat (18) @(posedge sys_clk);
                strobe(8'h33);
            end
        join
        n_vec++;
        if (bits[19:0] !== {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}) begin n_err++; $display("FAIL ovf_frames: got %h expected %h", bits[19:0], {1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}); end
        n_vec++;
        if (oc !== 1) begin n_err++; $display("FAIL ovf_pulse: got %0d expected 1", oc); end
        @(negedge sys_clk);
        n_vec++;
        if (busy_w[0] !== 1'b0) begin n_err++; $display("FAIL ovf_dropped: busy=%b expected 0", busy_w[0]); end
        wait_idle();
    endtask

    task automatic test_parity();
        logic [31:0] be, bo;
        int fle, dce, die, oce, ble;
        int flo, dco, dio, oco, blo;
        strobe(8'h07);
        fork
            capture(1, 12, be, fle, dce, die, oce, ble);
            capture(2, 12, bo, flo, dco, dio, oco, blo);
        join
        n_vec++;
        if (be[11:0] !== {2'b11, 1'b1, 8'h07, 1'b0}) begin n_err++; $display("FAIL parity_even: got %h expected %h", be[11:0], {2'b11, 1'b1, 8'h07, 1'b0}); end
        n_vec++;
        if (bo[11:0] !== {2'b11, 1'b0, 8'h07, 1'b0}) begin n_err++; $display("FAIL parity_odd: got %h expected %h", bo[11:0], {2'b11, 1'b0, 8'h07, 1'b0}); end
        n_vec++;
        if (dce !== 1 || die !== 120) begin n_err++; $display("FAIL parity_len: done count %0d at %0d expected 1 at 120", dce, die); end
        @(negedge sys_clk);
        n_vec++;
        if (busy_w[2:1] !== 2'b00) begin n_err++; $display("FAIL parity_after: busy=%b expected 00", busy_w[2:1]); end
        wait_idle();
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] bits;
        int fl, dc, di, oc, bl;
        strobe(8'hF0);
        repeat (40) @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
        n_vec++;
        if (tx_w[0] !== 1'b0) begin n_err++; $display("FAIL midreset_pre: tx=%b expected 0", tx_w[0]); end
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if (tx_w !== 3'b111 || busy_w !== 3'b000) begin n_err++; $display("FAIL midreset_async: tx=%b busy=%b expected 111 000", tx_w, busy_w); end
        repeat (3) @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        n_vec++;
        if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin n_err++; $display("FAIL midreset_idle: tx=%b busy=%b expected 1 0", tx_w[0], busy_w[0]); end
        strobe(8'h81);
        capture(0, 10, bits, fl, dc, di, oc, bl);
        n_vec++;
        if (bits[9:0] !== {1'b1, 8'h81, 1'b0}) begin n_err++; $display("FAIL midreset_frame: got %h expected %h", bits[9:0], {1'b1, 8'h81, 1'b0}); end
        n_vec++;
        if (fl !== 1 || dc !== 1) begin n_err++; $display("FAIL midreset_timing: first low %0d done %0d expected 1 1", fl, dc); end
        wait_idle();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_parity();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
